// File: rtl/decode.sv
// decode: ID stage (field decode, 32x32 regfile, load-use stall, ID_EX latch); define DECODE_BYPASS_EN for same-cycle writeback forwarding
module decode #(
   parameter int NREGS = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] IF_ID,
   input  logic        if_valid,
   input  logic        branchFlag,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        stall,
   output logic        id_ex_valid,
   output logic [31:0] id_ex_pc,
   output logic [5:0]  id_ex_opcode,
   output logic [5:0]  id_ex_funct,
   output logic [31:0] id_ex_rs_val,
   output logic [31:0] id_ex_rt_val,
   output logic [31:0] id_ex_imm,
   output logic [4:0]  id_ex_dest,
   output logic        id_ex_is_load,
   output logic        id_ex_illegal
);
   logic [31:0] rf [NREGS];
   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd, dest;
   logic [15:0] imm16;
   logic [31:0] imm, rs_val, rt_val;
   logic        is_r, is_addi, is_andi, is_ori, is_lui, is_lw, is_sw, is_beq;
   logic        illegal, use_rs, use_rt, hit, bubble;

   assign opcode  = IF_ID[31:26];
   assign rs      = IF_ID[25:21];
   assign rt      = IF_ID[20:16];
   assign rd      = IF_ID[15:11];
   assign imm16   = IF_ID[15:0];
   assign is_r    = opcode == 6'b000000;
   assign is_addi = opcode == 6'b001000;
   assign is_andi = opcode == 6'b001100;
   assign is_ori  = opcode == 6'b001101;
   assign is_lui  = opcode == 6'b001111;
   assign is_lw   = opcode == 6'b100011;
   assign is_sw   = opcode == 6'b101011;
   assign is_beq  = opcode == 6'b000100;
   assign illegal = !(is_r | is_addi | is_andi | is_ori | is_lui | is_lw | is_sw | is_beq);
   assign use_rs  = is_r | is_addi | is_andi | is_ori | is_lw | is_sw | is_beq;
   assign use_rt  = is_r | is_sw | is_beq;
   assign dest    = is_r ? rd : (is_addi | is_andi | is_ori | is_lui | is_lw) ? rt : 5'd0;
   assign imm     = is_lui ? {imm16, 16'h0} : (is_andi | is_ori) ? {16'h0, imm16} : {{16{imm16[15]}}, imm16};

`ifdef DECODE_BYPASS_EN
   assign rs_val = (rs == 5'd0) ? 32'h0 : (wb_en && wb_addr == rs) ? wb_data : rf[rs];
   assign rt_val = (rt == 5'd0) ? 32'h0 : (wb_en && wb_addr == rt) ? wb_data : rf[rt];
`else
   assign rs_val = (rs == 5'd0) ? 32'h0 : rf[rs];
   assign rt_val = (rt == 5'd0) ? 32'h0 : rf[rt];
`endif

   assign hit    = (use_rs && rs == id_ex_dest) || (use_rt && rt == id_ex_dest);
   assign stall  = !branchFlag && if_valid && id_ex_valid && id_ex_is_load && id_ex_dest != 5'd0 && hit;
   assign bubble = branchFlag || stall || !if_valid;

   // register file: r0 is never written so it stays zero
   always_ff @(posedge clock or negedge reset)
      if (!reset)
         for (int i = 0; i < NREGS; i++) rf[i] <= 32'h0;
      else if (wb_en && wb_addr != 5'd0)
         rf[wb_addr] <= wb_data;

   // ID_EX latch: decoded instruction, or an all-zero bubble on flush/stall/idle
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         id_ex_valid   <= 1'b0;
         id_ex_pc      <= 32'h0;
         id_ex_opcode  <= 6'h0;
         id_ex_funct   <= 6'h0;
         id_ex_rs_val  <= 32'h0;
         id_ex_rt_val  <= 32'h0;
         id_ex_imm     <= 32'h0;
         id_ex_dest    <= 5'h0;
         id_ex_is_load <= 1'b0;
         id_ex_illegal <= 1'b0;
      end else begin
         id_ex_valid   <= !bubble;
         id_ex_pc      <= bubble ? 32'h0 : IF_ID[63:32];
         id_ex_opcode  <= bubble ? 6'h0 : opcode;
         id_ex_funct   <= bubble ? 6'h0 : IF_ID[5:0];
         id_ex_rs_val  <= bubble ? 32'h0 : rs_val;
         id_ex_rt_val  <= bubble ? 32'h0 : rt_val;
         id_ex_imm     <= bubble ? 32'h0 : imm;
         id_ex_dest    <= bubble ? 5'h0 : dest;
         id_ex_is_load <= !bubble && is_lw;
         id_ex_illegal <= !bubble && illegal;
      end
endmodule

// File: doc/decode.md
# decode

Second pipeline stage. Consumes the 64-bit `IF_ID` latch from fetch (`[63:32]` pc, `[31:0]` instruction) and decodes MIPS-style instruction fields. Reads a 32x32 register file with a writeback port, and detects load-use hazards, stalling fetch for one cycle when one occurs. Results are registered into the `ID_EX` latch that feeds execute.

## Interface
- `NREGS`, default 32: register-file depth. Fixed at 32; r0 is hardwired to zero.
- `clock` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `IF_ID` input 64: fetch latch; `[63:32]` pc, `[31:0]` instruction.
- `if_valid` input 1: `IF_ID` holds a real instruction this cycle.
- `branchFlag` input 1: flush; discards the instruction currently in decode.
- `wb_en` input 1: register-file write enable.
- `wb_addr` input 5: register-file write address.
- `wb_data` input 32: register-file write data.
- `stall` output 1: combinational; fetch must hold `IF_ID` and pc.
- `id_ex_valid` output 1: the `ID_EX` latch holds a real instruction.
- `id_ex_pc` output 32: pc of the decoded instruction.
- `id_ex_opcode` output 6: `instr[31:26]`.
- `id_ex_funct` output 6: `instr[5:0]`.
- `id_ex_rs_val` output 32: value of register rs.
- `id_ex_rt_val` output 32: value of register rt.
- `id_ex_imm` output 32: extended immediate.
- `id_ex_dest` output 5: destination register; 0 means no write.
- `id_ex_is_load` output 1: the instruction is LW.
- `id_ex_illegal` output 1: the opcode is unsupported.

## Operation
- Field extraction: rs = `[25:21]`, rt = `[20:16]`, rd = `[15:11]`, imm = `[15:0]`.
- R-type (opcode 000000): dest = rd; uses rs and rt.
- ADDI (001000): dest = rt; uses rs; imm sign-extended.
- ANDI (001100) and ORI (001101): dest = rt; uses rs; imm zero-extended.
- LUI (001111): dest = rt; imm = `{imm,16'h0}`; uses no source registers.
- LW (100011): dest = rt; uses rs; imm sign-extended; `is_load` = 1.
- SW (101011) and BEQ (000100): dest = 0; use rs and rt; imm sign-extended.
- Any other opcode: `illegal` = 1, dest = 0, uses no source registers; the instruction is still passed down as valid.
- Register file:
  - Reads of r0 return 0.
  - Writes with `wb_addr` = 0 are ignored.
  - The write occurs at the clock edge when `wb_en` = 1.
- Load-use hazard: `stall` = `if_valid & id_ex_valid & id_ex_is_load & (id_ex_dest != 0) & (id_ex_dest` matches a source register the current instruction uses`)`.
  - While `stall` = 1, `ID_EX` is loaded with a bubble: valid = 0 and all other fields = 0.
  - Decode re-evaluates the same `IF_ID` on the next cycle; because the bubble has valid = 0, `stall` drops after exactly one cycle.
- Flush: `branchFlag` = 1 loads a bubble into `ID_EX` and forces `stall` = 0. Flush has priority over stall.
- If `if_valid` = 0, a bubble is loaded.

## Timing
- Latency: one cycle. Fields of `IF_ID` sampled at edge N appear on `id_ex_*` after edge N.
- `stall` is combinational from `IF_ID`, `if_valid`, `branchFlag` and the `ID_EX` registers. It has no dependence on `wb_*`.
- Writeback and read of the same register in the same cycle: governed by `DECODE_BYPASS_EN` (see Configuration).
- Reset asserted (`reset` = 0):
  - All `id_ex_*` outputs are 0 immediately (asynchronously).
  - All 32 registers are cleared to 0.
  - `stall` = 0 because `id_ex_valid` = 0.
- Reset asserted mid-stall: the stall is abandoned; after release, decode resumes with the current `IF_ID`.

## Configuration
- `DECODE_BYPASS_EN` defined: when `wb_en` & (`wb_addr` == rs or rt) & (`wb_addr` != 0), `wb_data` is forwarded to the read value in the same cycle.
- `DECODE_BYPASS_EN` undefined: reads return the pre-edge register contents. Software must separate a writer and a reader of the same register by two instructions.

## Test plan
- Reset release, then `IF_ID` = {32'h0, 32'h3C01_1234} (LUI r1) with `if_valid` = 1:
  - `id_ex_imm` = 32'h1234_0000, `id_ex_dest` = 1, `id_ex_pc` = 0, `id_ex_valid` = 1 one cycle later.
- ADDI r2, r0, -1 (32'h2002_FFFF):
  - `id_ex_imm` = 32'hFFFF_FFFF.
  - ORI r2, r0, 16'hFFFF gives `id_ex_imm` = 32'h0000_FFFF.
- LW r3, 0(r0) followed by ADD r4, r3, r0:
  - `stall` = 1 for exactly one cycle; a bubble is loaded (`id_ex_valid` = 0); the ADD is then issued with `id_ex_dest` = 4.
- Same cycle: `wb_en` = 1, `wb_addr` = 5, `wb_data` = 32'hDEAD_BEEF, and `IF_ID` reads r5:
  - With the macro defined, `id_ex_rs_val` = 32'hDEAD_BEEF.
  - Without it, `id_ex_rs_val` = the old value (0).
- Load-use stall condition present with `branchFlag` = 1 in the same cycle:
  - `stall` = 0 and `id_ex_valid` = 0.
  - Write to r0 with 32'h1234: a subsequent read of r0 returns 0.
- `reset` pulsed low asynchronously mid-stream:
  - All `id_ex_*` outputs read 0 before the next clock edge.
  - After release, registers read 0.
